// File: rtl/wb_sram_resp_pkg.sv
// rtl/wb_sram_resp_pkg.sv - shared types and byte-lane mapping for the Wishbone SRAM responder
package wb_sram_resp_pkg;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} wbsram_state_t;

  localparam int LANES  = 4;
  localparam int LANE_W = 8;

  // Big-endian lanes: sel[3] is byte offset 0 and lives in dat[31:24].
  function automatic int lane_lsb(input int lane);
    return lane * LANE_W;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    lane_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      if (sel[i]) lane_mask[lane_lsb(i) +: LANE_W] = '1;
    end
  endfunction

endpackage

// File: rtl/wb_sram_resp_if.sv
// rtl/wb_sram_resp_if.sv - Wishbone pipelined bus bundle between memory-stage master and SRAM responder
interface wb_sram_resp_if;
  logic        cyc_i;
  logic        stb_i;
  logic        we_i;
  logic [3:0]  sel_i;
  logic [31:0] adr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack_o;
  logic        stall_o;

  modport master (
    output cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
    input  dat_o, ack_o, stall_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
    output dat_o, ack_o, stall_o
  );
endinterface

// File: rtl/wb_sram_array.sv
// rtl/wb_sram_array.sv - single-port byte-enabled synchronous RAM, read-old-data
module wb_sram_array
  import wb_sram_resp_pkg::*;
#(
  parameter int    AWIDTH    = 12,
  parameter string INIT_FILE = ""
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [AWIDTH-1:0] addr_i,
  input  logic [31:0]       dat_i,
  output logic [31:0]       dat_o
);

  logic [31:0] mem_q [2**AWIDTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < LANES; i++) begin
      if (we_i && be_i[i]) mem_q[addr_i][lane_lsb(i) +: LANE_W] <= dat_i[lane_lsb(i) +: LANE_W];
    end
    rdata_q <= mem_q[addr_i];
  end

  assign dat_o = rdata_q;

endmodule

// File: rtl/wb_sram_resp.sv
// rtl/wb_sram_resp.sv - Wishbone responder for on-chip data/stack SRAM with programmable wait states
// Optional WB_SRAM_RDMASK_EN: zero read-data lanes not selected at acceptance.
module wb_sram_resp
  import wb_sram_resp_pkg::*;
#(
  parameter int    AWIDTH      = 12,
  parameter int    WAIT_STATES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic           clk_i,
  input  logic           rst_i,
  wb_sram_resp_if.slave  bus
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  wbsram_state_t     state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q;
  logic [AWIDTH-1:0] addr_q;
  logic [31:0]       dat_q;
  logic [31:0]       dat_o_w;
  logic [31:0]       ram_rdata;
  logic [31:0]       rd_word;
  logic [AWIDTH-1:0] ram_addr;
  logic              accept;
  logic              unused_adr;

  assign accept     = bus.cyc_i & bus.stb_i & (state_q == S_IDLE);
  assign unused_adr = ^{bus.adr_i[31:AWIDTH+2], bus.adr_i[1:0]};

  // The RAM keeps re-reading the accepted word while busy, so its registered
  // output stays valid for the ack cycle whatever the master does to adr_i.
  assign ram_addr = (state_q == S_IDLE) ? bus.adr_i[AWIDTH+1:2] : addr_q;

  wb_sram_array #(
    .AWIDTH    (AWIDTH),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clk_i  (clk_i),
    .we_i   (accept & bus.we_i),
    .be_i   (bus.sel_i),
    .addr_i (ram_addr),
    .dat_i  (bus.dat_i),
    .dat_o  (ram_rdata)
  );

`ifdef WB_SRAM_RDMASK_EN
  logic [3:0] sel_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       sel_q <= '0;
    else if (accept) sel_q <= bus.sel_i;
  end

  assign rd_word = ram_rdata & lane_mask(sel_q);
`else
  assign rd_word = ram_rdata;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dat_q   <= dat_o_w;
      if (accept) begin
        we_q   <= bus.we_i;
        addr_q <= bus.adr_i[AWIDTH+1:2];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d   = WS;
          state_d = (WS != 4'd0) ? S_WAIT : S_ACK;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (!bus.cyc_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 4'd1) begin
          state_d = S_ACK;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Read data is presented straight from the RAM register in the ack cycle and
  // held in dat_q afterwards; writes leave the previous value on dat_o.
  always_comb begin
    bus.ack_o   = (state_q == S_ACK);
    bus.stall_o = (state_q != S_IDLE);
    dat_o_w     = dat_q;
    if ((state_q == S_ACK) && !we_q) dat_o_w = rd_word;
    bus.dat_o   = dat_o_w;
  end

endmodule

// File: tb/tb_wb_sram_resp.sv
// tb/tb_wb_sram_resp.sv - self-checking bench for wb_sram_resp across three wait-state/depth builds
module tb_wb_sram_resp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_sram_resp_if b0();
  wb_sram_resp_if b1();
  wb_sram_resp_if b2();

  wb_sram_resp #(.AWIDTH(4),  .WAIT_STATES(1), .INIT_FILE("")) u0 (.clk_i(clk), .rst_i(rst), .bus(b0));
  wb_sram_resp #(.AWIDTH(12), .WAIT_STATES(0), .INIT_FILE("")) u1 (.clk_i(clk), .rst_i(rst), .bus(b1));
  wb_sram_resp #(.AWIDTH(6),  .WAIT_STATES(3), .INIT_FILE("")) u2 (.clk_i(clk), .rst_i(rst), .bus(b2));

  int checks = 0;
  int errors = 0;

  int ws_of [3] = '{1, 0, 3};
  int aw_of [3] = '{4, 12, 6};

  logic [31:0] mem [3][16];
  logic [31:0] prev_dat [3];

  virtual wb_sram_resp_if vif;

  typedef struct {
    bit          we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_dut(input int d);
    case (d)
      0:       vif = b0;
      1:       vif = b1;
      default: vif = b2;
    endcase
  endtask

  task automatic idle_bus(input int d);
    set_dut(d);
    vif.cyc_i = 1'b0; vif.stb_i = 1'b0; vif.we_i = 1'b0;
    vif.sel_i = '0;   vif.adr_i = '0;   vif.dat_i = '0;
  endtask

  // Reference: word = byte address / 4 modulo depth; lanes written where sel is set;
  // reads return the word (optionally lane-masked), writes leave dat_o unchanged.
  task automatic model(input int d, input bit we, input logic [3:0] sel, input logic [31:0] adr,
                       input logic [31:0] dat, output logic [31:0] exp);
    int w;
    w = int'((adr >> 2) % (32'd1 << aw_of[d]));
    if (we) begin
      for (int i = 0; i < 4; i++) if (sel[i]) mem[d][w][8*i +: 8] = dat[8*i +: 8];
      exp = prev_dat[d];
    end else begin
      exp = mem[d][w];
`ifdef WB_SRAM_RDMASK_EN
      for (int i = 0; i < 4; i++) if (!sel[i]) exp[8*i +: 8] = 8'h00;
`endif
      prev_dat[d] = exp;
    end
  endtask

  // Single-cycle stb master; checks ack latency, single ack and stall length.
  task automatic xfer(input int d, input bit we, input logic [3:0] sel, input logic [31:0] adr,
                      input logic [31:0] dat, output logic [31:0] rdat);
    int ws, first_ack, nack, nstall;
    ws = ws_of[d]; first_ack = -1; nack = 0; nstall = 0; rdat = '0;
    set_dut(d);
    @(negedge clk);
    vif.cyc_i = 1'b1; vif.stb_i = 1'b1; vif.we_i = we;
    vif.sel_i = sel;  vif.adr_i = adr;  vif.dat_i = dat;
    @(negedge clk);
    vif.stb_i = 1'b0;
    for (int i = 0; i < ws + 2; i++) begin
      if (i > 0) @(negedge clk);
      if (vif.ack_o) begin
        nack++;
        if (first_ack < 0) begin first_ack = i; rdat = vif.dat_o; end
      end
      if (vif.stall_o) nstall++;
    end
    idle_bus(d);
    check($sformatf("ack_latency d%0d", d), 32'(first_ack), 32'(ws));
    check($sformatf("ack_count d%0d", d), 32'(nack), 32'd1);
    check($sformatf("stall_cycles d%0d", d), 32'(nstall), 32'(ws + 1));
  endtask

  task automatic xfer_model(input int d, input bit we, input logic [3:0] sel, input logic [31:0] adr,
                            input logic [31:0] dat, input string name);
    logic [31:0] got, exp;
    model(d, we, sel, adr, dat, exp);
    xfer(d, we, sel, adr, dat, got);
    check(name, got, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got, exp, adr, mask;
    logic [5:0]  ackv, stallv, expa, exps;
    int nack;

    tbl[0] = '{1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000};
    tbl[1] = '{1'b0, 4'hF, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
    tbl[2] = '{1'b1, 4'h4, 32'h0000_0010, 32'h00AA_0000, 32'hDEAD_BEEF};
    tbl[3] = '{1'b0, 4'hF, 32'h0000_0013, 32'h0,         32'hDEAA_BEEF};
`ifdef WB_SRAM_RDMASK_EN
    tbl[4] = '{1'b0, 4'h4, 32'h0000_0010, 32'h0,         32'h00AA_0000};
    tbl[5] = '{1'b1, 4'hF, 32'h0000_0040, 32'hCAFE_F00D, 32'h00AA_0000};
    tbl[8] = '{1'b0, 4'h3, 32'hFFFF_FF00, 32'h0,         32'h0000_F00D};
`else
    tbl[4] = '{1'b0, 4'h4, 32'h0000_0010, 32'h0,         32'hDEAA_BEEF};
    tbl[5] = '{1'b1, 4'hF, 32'h0000_0040, 32'hCAFE_F00D, 32'hDEAA_BEEF};
    tbl[8] = '{1'b0, 4'h3, 32'hFFFF_FF00, 32'h0,         32'hCAFE_F00D};
`endif
    tbl[6] = '{1'b0, 4'hF, 32'h0000_0000, 32'h0,         32'hCAFE_F00D};
    tbl[7] = '{1'b1, 4'h0, 32'h0000_0000, 32'hFFFF_FFFF, 32'hCAFE_F00D};
    tbl[9] = '{1'b0, 4'hF, 32'h0000_0010, 32'h0,         32'hDEAA_BEEF};

    for (int d = 0; d < 3; d++) begin
      idle_bus(d);
      prev_dat[d] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int d = 0; d < 3; d++) begin
      set_dut(d);
      check($sformatf("reset_ack d%0d", d), 32'(vif.ack_o), 32'd0);
      check($sformatf("reset_stall d%0d", d), 32'(vif.stall_o), 32'd0);
      check($sformatf("reset_dat d%0d", d), vif.dat_o, 32'h0);
    end

    for (int i = 0; i < 10; i++) begin
      model(0, tbl[i].we, tbl[i].sel, tbl[i].adr, tbl[i].dat, exp);
      xfer(0, tbl[i].we, tbl[i].sel, tbl[i].adr, tbl[i].dat, got);
      check($sformatf("tbl%0d", i), got, tbl[i].exp);
    end

    // Abort: cyc drops while waiting; no ack, back to idle, write stays committed.
    xfer_model(0, 1'b1, 4'hF, 32'h20, 32'h1234_5678, "abort_wr");
    set_dut(0);
    @(negedge clk);
    vif.cyc_i = 1'b1; vif.stb_i = 1'b1; vif.we_i = 1'b0; vif.sel_i = 4'hF; vif.adr_i = 32'h20;
    @(negedge clk);
    vif.cyc_i = 1'b0; vif.stb_i = 1'b0;
    check("abort_wait_stall", 32'(vif.stall_o), 32'd1);
    nack = int'(vif.ack_o);
    @(negedge clk);
    check("abort_idle_stall", 32'(vif.stall_o), 32'd0);
    nack += int'(vif.ack_o);
    @(negedge clk);
    nack += int'(vif.ack_o);
    check("abort_no_ack", 32'(nack), 32'd0);
    idle_bus(0);
    model(0, 1'b0, 4'hF, 32'h20, 32'h0, exp);
    xfer(0, 1'b0, 4'hF, 32'h20, 32'h0, got);
    check("abort_readback", got, 32'h1234_5678);

    // Zero wait states with stb held: one ack per acceptance, accept every 2nd edge.
    xfer_model(1, 1'b1, 4'hF, 32'h0C, 32'h600D_F00D, "b2b_wr");
    set_dut(1);
    @(negedge clk);
    vif.cyc_i = 1'b1; vif.stb_i = 1'b1; vif.we_i = 1'b0; vif.sel_i = 4'hF; vif.adr_i = 32'h0C;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ackv[i]   = vif.ack_o;
      stallv[i] = vif.stall_o;
      expa[i]   = ((i % (ws_of[1] + 2)) == ws_of[1]);
      exps[i]   = ((i % (ws_of[1] + 2)) <= ws_of[1]);
      if (vif.ack_o) begin
        model(1, 1'b0, 4'hF, 32'h0C, 32'h0, exp);
        check("b2b_data", vif.dat_o, exp);
      end
    end
    idle_bus(1);
    check("b2b_ack_pattern", 32'(ackv), 32'(expa));
    check("b2b_stall_pattern", 32'(stallv), 32'(exps));

    // Asynchronous reset in the middle of a wait.
    xfer_model(2, 1'b1, 4'hF, 32'h14, 32'hA5A5_5A5A, "rst_wr");
    set_dut(2);
    @(negedge clk);
    vif.cyc_i = 1'b1; vif.stb_i = 1'b1; vif.we_i = 1'b0; vif.sel_i = 4'hF; vif.adr_i = 32'h14;
    @(negedge clk);
    vif.stb_i = 1'b0;
    @(negedge clk);
    check("rst_pre_stall", 32'(vif.stall_o), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_async_stall", 32'(vif.stall_o), 32'd0);
    check("rst_async_ack", 32'(vif.ack_o), 32'd0);
    check("rst_async_dat", vif.dat_o, 32'h0);
    idle_bus(2);
    for (int d = 0; d < 3; d++) prev_dat[d] = '0;
    @(negedge clk);
    rst = 1'b0;
    nack = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      nack += int'(vif.ack_o);
    end
    check("rst_no_late_ack", 32'(nack), 32'd0);
    model(2, 1'b0, 4'hF, 32'h14, 32'h0, exp);
    xfer(2, 1'b0, 4'hF, 32'h14, 32'h0, got);
    check("rst_ram_intact", got, 32'hA5A5_5A5A);

    // Random traffic against the model, with random upper/low address bits.
    for (int d = 0; d < 3; d++) begin
      mask = ((32'd1 << aw_of[d]) - 32'd1) << 2;
      for (int w = 0; w < 16; w++)
        xfer_model(d, 1'b1, 4'hF, 32'(w) << 2, $urandom, $sformatf("init d%0d w%0d", d, w));
      for (int n = 0; n < 30; n++) begin
        adr = ($urandom & ~mask) | (32'($urandom_range(0, 15)) << 2);
        xfer_model(d, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), adr, $urandom,
                   $sformatf("rand d%0d n%0d", d, n));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
